// File: rtl/riscv_exec_pkg.sv
// rtl/riscv_exec_pkg.sv - shared types and constants for the RV32 execution back-end
package riscv_exec_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alu_op_e;

endpackage

// File: rtl/exec_alu.sv
// rtl/exec_alu.sv - combinational 32-bit ALU with zero flag; ALU_EXT_OPS_EN adds SLT and NOR
module exec_alu
    import riscv_exec_pkg::*;
(
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] ALUout,
    output logic            zero
);

    always_comb begin
        ALUout = '0;
        case (ALUctl)
            ALU_AND: ALUout = A & B;
            ALU_OR:  ALUout = A | B;
            ALU_ADD: ALUout = A + B;
            ALU_SUB: ALUout = A - B;
`ifdef ALU_EXT_OPS_EN
            ALU_SLT: ALUout = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
            ALU_NOR: ALUout = ~(A | B);
`endif
            default: ALUout = '0;
        endcase
    end

    // Derived from the result so a SUB followed by zero implements BEQ.
    assign zero = (ALUout == '0);

endmodule

// File: rtl/riscv_exec_core.sv
// rtl/riscv_exec_core.sv - PC register, ALU and word data memory of the single-cycle RV32 core (option: ALU_EXT_OPS_EN)
module riscv_exec_core
    import riscv_exec_pkg::*;
#(
    parameter int              DMEM_WORDS = 256,
    parameter logic [XLEN-1:0] PC_RESET   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            finish_flag,
    input  logic            branch,
    input  logic [XLEN-1:0] branch_offset,
    output logic [XLEN-1:0] pc_reg,
    input  logic [3:0]      ALUctl,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] ALUout,
    output logic            zero,
    input  logic            write_enable,
    input  logic            read_enable,
    input  logic [XLEN-1:0] address,
    input  logic [XLEN-1:0] write_data,
    output logic [XLEN-1:0] read_data
);

    localparam int AW = $clog2(DMEM_WORDS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= PC_RESET;
        end else if (finish_flag) begin
            pc_reg <= pc_reg;
        end else if (branch) begin
            pc_reg <= pc_reg + branch_offset;
        end else begin
            pc_reg <= pc_reg + PC_INC;
        end
    end

    exec_alu u_alu (
        .ALUctl (ALUctl),
        .A      (A),
        .B      (B),
        .ALUout (ALUout),
        .zero   (zero)
    );

    // Byte offset and high bits are dropped: misaligned accesses truncate, out-of-range ones wrap.
    logic [XLEN-1:0] mem [DMEM_WORDS];
    logic [AW-1:0]   word_idx;
    logic            unused_addr_bits;

    assign word_idx         = address[AW+1:2];
    assign unused_addr_bits = ^{address[XLEN-1:AW+2], address[1:0]};

    // Deliberately outside the reset domain so stores during reset still land.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[word_idx] <= write_data;
        end
    end

    assign read_data = read_enable ? mem[word_idx] : '0;

endmodule

// File: tb/tb_riscv_exec_core.sv
// tb/tb_riscv_exec_core.sv - directed self-checking bench for riscv_exec_core
module tb_riscv_exec_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        finish_flag;
    logic        branch;
    logic [31:0] branch_offset;
    logic [31:0] pc_reg;
    logic [3:0]  ALUctl;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] ALUout;
    logic        zero;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int errors = 0;
    int checks = 0;

    riscv_exec_core #(.DMEM_WORDS(256), .PC_RESET(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .finish_flag   (finish_flag),
        .branch        (branch),
        .branch_offset (branch_offset),
        .pc_reg        (pc_reg),
        .ALUctl        (ALUctl),
        .A             (A),
        .B             (B),
        .ALUout        (ALUout),
        .zero          (zero),
        .write_enable  (write_enable),
        .read_enable   (read_enable),
        .address       (address),
        .write_data    (write_data),
        .read_data     (read_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; finish_flag = 1'b0; branch = 1'b0; branch_offset = 32'h0;
        ALUctl = 4'd0; A = 32'h0; B = 32'h0;
        write_enable = 1'b0; read_enable = 1'b0; address = 32'h0; write_data = 32'h0;
        #3;
        checks++;
        if (pc_reg !== 32'h0) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", pc_reg, 32'h0);
        end
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL reset_read_data: got %h expected %h", read_data, 32'h0);
        end
        tick();
        checks++;
        if (pc_reg !== 32'h0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", pc_reg, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (pc_reg !== 32'(4 * i)) begin
                errors++; $display("FAIL pc_increment_%0d: got %h expected %h", i, pc_reg, 32'(4 * i));
            end
        end
        // asynchronous reset assertion between edges
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (pc_reg !== 32'h0) begin
            errors++; $display("FAIL async_reset: got %h expected %h", pc_reg, 32'h0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_branch();
        tick(); tick();
        checks++;
        if (pc_reg !== 32'd8) begin
            errors++; $display("FAIL pc_at_8: got %h expected %h", pc_reg, 32'd8);
        end
        @(negedge clk);
        branch = 1'b1; branch_offset = 32'hFFFF_FFF8;
        tick();
        checks++;
        if (pc_reg !== 32'd0) begin
            errors++; $display("FAIL branch_neg8: got %h expected %h", pc_reg, 32'd0);
        end
        @(negedge clk);
        branch_offset = 32'd8;
        tick();
        @(negedge clk);
        branch_offset = 32'd16;
        tick();
        checks++;
        if (pc_reg !== 32'd24) begin
            errors++; $display("FAIL branch_pos16: got %h expected %h", pc_reg, 32'd24);
        end
        @(negedge clk);
        finish_flag = 1'b1;
        tick();
        checks++;
        if (pc_reg !== 32'd24) begin
            errors++; $display("FAIL finish_over_branch: got %h expected %h", pc_reg, 32'd24);
        end
        @(negedge clk);
        branch = 1'b0;
        tick();
        checks++;
        if (pc_reg !== 32'd24) begin
            errors++; $display("FAIL finish_hold: got %h expected %h", pc_reg, 32'd24);
        end
        @(negedge clk);
        finish_flag = 1'b0;
        tick();
        checks++;
        if (pc_reg !== 32'd28) begin
            errors++; $display("FAIL resume_after_finish: got %h expected %h", pc_reg, 32'd28);
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops [6] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd2, 4'd3};
        logic [31:0] as  [6] = '{32'hF0, 32'hF0, 32'hF0, 32'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bs  [6] = '{32'h3C, 32'h3C, 32'h3C, 32'd5, 32'd1, 32'hFFFF_FFFF};
        logic [31:0] exp [6] = '{32'h30, 32'hFC, 32'h12C, 32'h0, 32'h8000_0000, 32'h0};
        logic        exz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            ALUctl = ops[i]; A = as[i]; B = bs[i];
            #1;
            checks++;
            if (ALUout !== exp[i]) begin
                errors++; $display("FAIL alu_vec%0d_out: got %h expected %h", i, ALUout, exp[i]);
            end
            checks++;
            if (zero !== exz[i]) begin
                errors++; $display("FAIL alu_vec%0d_zero: got %b expected %b", i, zero, exz[i]);
            end
        end
    endtask

    task automatic test_alu_ext();
        logic [31:0] exp_slt;
        logic [31:0] exp_nor;
`ifdef ALU_EXT_OPS_EN
        exp_slt = 32'd1;
        exp_nor = 32'hFFFF_FFFF;
`else
        exp_slt = 32'd0;
        exp_nor = 32'd0;
`endif
        ALUctl = 4'd7; A = 32'hFFFF_FFFF; B = 32'd1;
        #1;
        checks++;
        if (ALUout !== exp_slt) begin
            errors++; $display("FAIL alu_slt: got %h expected %h", ALUout, exp_slt);
        end
        ALUctl = 4'd12; A = 32'h0; B = 32'h0;
        #1;
        checks++;
        if (ALUout !== exp_nor) begin
            errors++; $display("FAIL alu_nor: got %h expected %h", ALUout, exp_nor);
        end
    endtask

    task automatic test_memory();
        logic [31:0] addrs [3] = '{32'd8, 32'd9, 32'd8 + 32'd1024};
        @(negedge clk);
        write_enable = 1'b1; address = 32'd8; write_data = 32'hDEAD_BEEF;
        tick();
        @(negedge clk);
        write_enable = 1'b0; read_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            address = addrs[i];
            #1;
            checks++;
            if (read_data !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL mem_read_addr_%0d: got %h expected %h", addrs[i], read_data, 32'hDEAD_BEEF);
            end
        end
        read_enable = 1'b0;
        #1;
        checks++;
        if (read_data !== 32'h0) begin
            errors++; $display("FAIL mem_read_disabled: got %h expected %h", read_data, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        address = 32'd8; write_data = 32'h1234_5678; write_enable = 1'b1; read_enable = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL same_edge_old: got %h expected %h", read_data, 32'hDEAD_BEEF);
        end
        tick();
        checks++;
        if (read_data !== 32'h1234_5678) begin
            errors++; $display("FAIL same_edge_new: got %h expected %h", read_data, 32'h1234_5678);
        end
        // store strobed while reset is held low must still land
        @(negedge clk);
        reset = 1'b0; address = 32'd16; write_data = 32'hA5A5_A5A5; read_enable = 1'b0;
        tick();
        @(negedge clk);
        write_enable = 1'b0; reset = 1'b1; read_enable = 1'b1;
        #1;
        checks++;
        if (read_data !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL write_during_reset: got %h expected %h", read_data, 32'hA5A5_A5A5);
        end
        checks++;
        if (pc_reg !== 32'h0) begin
            errors++; $display("FAIL pc_after_reset_pulse: got %h expected %h", pc_reg, 32'h0);
        end
        read_enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_alu();
        test_alu_ext();
        test_memory();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
